// File: rtl/l2_cache_if.sv
// Bus bundle between the L1 cache, the L2 cache and main memory.
//   l1_*  : request/response channel from the L1 (level request, one-cycle l1_ready pulse)
//   mem_* : line-granular memory channel (mem_read/mem_write held until mem_ready)
// Modports: slave = the L2 cache itself, master = the environment (L1 + memory).
interface l2_cache_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] l1_addr;
  logic [DATA_WIDTH-1:0] l1_data_in;
  logic [DATA_WIDTH-1:0] l1_data_out;
  logic                  l1_read;
  logic                  l1_write;
  logic                  l1_ready;
  logic                  l1_hit;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_read;
  logic                  mem_write;
  logic                  mem_ready;

  modport slave (
    input  l1_addr, l1_data_in, l1_read, l1_write, mem_data_in, mem_ready,
    output l1_data_out, l1_ready, l1_hit, mem_addr, mem_data_out, mem_read, mem_write
  );

  modport master (
    output l1_addr, l1_data_in, l1_read, l1_write, mem_data_in, mem_ready,
    input  l1_data_out, l1_ready, l1_hit, mem_addr, mem_data_out, mem_read, mem_write
  );
endinterface

// File: rtl/l2_cache.sv
// Second-level set-associative, write-back, write-allocate cache, one word per line.
// Serves one L1 request at a time; misses evict a dirty victim to memory before filling.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (valid/dirty/victim pointers cleared, contents lost)
//   bus   : l2_cache_if.slave carrying the L1 request channel and the memory channel
module l2_cache #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CACHE_SIZE = 4096,
  parameter int unsigned BLOCK_SIZE = 16,
  parameter int unsigned NUM_WAYS   = 8
) (
  input logic        clk,
  input logic        rst_n,
  l2_cache_if.slave  bus
);

  localparam int unsigned OFFSET_W = $clog2(BLOCK_SIZE);
  localparam int unsigned NUM_SETS = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
  localparam int unsigned INDEX_W  = $clog2(NUM_SETS);
  localparam int unsigned TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS);

  typedef enum logic [2:0] {
    StIdle, StLookup, StWriteback, StFill, StResp, StRelease
  } state_e;

  // Line storage
  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
  logic [WAY_W-1:0]      ptr_q   [NUM_SETS];

  // Control / request registers
  state_e                state_q, state_d;
  logic [TAG_W-1:0]      req_tag_q, req_tag_d;
  logic [INDEX_W-1:0]    req_index_q, req_index_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
  logic                  req_wr_q, req_wr_d;
  logic [WAY_W-1:0]      victim_q, victim_d;
  logic                  hit_q, hit_d;

  // Registered outputs
  logic [DATA_WIDTH-1:0] l1_data_out_q, l1_data_out_d;
  logic                  l1_ready_q, l1_ready_d;
  logic                  l1_hit_q, l1_hit_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_out_q, mem_data_out_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;

  // Single line write port into the arrays
  logic                  line_we;
  logic [WAY_W-1:0]      line_way;
  logic [TAG_W-1:0]      line_tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  line_dirty;
  logic                  ptr_inc;

  // Lookup results for the latched request
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic                  inv_found;
  logic [WAY_W-1:0]      inv_way;
  logic [WAY_W-1:0]      victim_way;

  // Byte-offset bits never matter: one word per line.
  logic unused_offset;
  assign unused_offset = ^bus.l1_addr[OFFSET_W-1:0];

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[req_index_q][w] && (tag_q[req_index_q][w] == req_tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[req_index_q][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    // Lowest invalid way first; round-robin only once the set is full.
    victim_way = inv_found ? inv_way : ptr_q[req_index_q];
  end

  always_comb begin
    state_d        = state_q;
    req_tag_d      = req_tag_q;
    req_index_d    = req_index_q;
    req_data_d     = req_data_q;
    req_wr_d       = req_wr_q;
    victim_d       = victim_q;
    hit_d          = hit_q;
    l1_data_out_d  = l1_data_out_q;
    l1_ready_d     = 1'b0;
    l1_hit_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_data_out_d = mem_data_out_q;
    mem_read_d     = mem_read_q;
    mem_write_d    = mem_write_q;
    line_we        = 1'b0;
    line_way       = victim_q;
    line_tag       = req_tag_q;
    line_data      = req_data_q;
    line_dirty     = 1'b1;
    ptr_inc        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.l1_read || bus.l1_write) begin
          req_tag_d   = bus.l1_addr[ADDR_WIDTH-1 -: TAG_W];
          req_index_d = bus.l1_addr[OFFSET_W +: INDEX_W];
          req_data_d  = bus.l1_data_in;
          req_wr_d    = bus.l1_write;  // write wins when both are asserted
          state_d     = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          hit_d   = 1'b1;
          state_d = StResp;
          if (req_wr_q) begin
            line_we  = 1'b1;
            line_way = hit_way;
          end else begin
            l1_data_out_d = data_q[req_index_q][hit_way];
          end
        end else begin
          hit_d    = 1'b0;
          victim_d = victim_way;
          ptr_inc  = !inv_found;
          if (valid_q[req_index_q][victim_way] && dirty_q[req_index_q][victim_way]) begin
            mem_write_d    = 1'b1;
            mem_addr_d     = {tag_q[req_index_q][victim_way], req_index_q, {OFFSET_W{1'b0}}};
            mem_data_out_d = data_q[req_index_q][victim_way];
            state_d        = StWriteback;
          end else if (req_wr_q) begin
            line_we  = 1'b1;
            line_way = victim_way;
            state_d  = StResp;
          end else begin
            mem_read_d = 1'b1;
            mem_addr_d = {req_tag_q, req_index_q, {OFFSET_W{1'b0}}};
            state_d    = StFill;
          end
        end
      end
      StWriteback: begin
        if (bus.mem_ready && mem_write_q) begin
          mem_write_d = 1'b0;
          line_we     = 1'b1;
          if (req_wr_q) begin
            state_d = StResp;
          end else begin
            // Keep the old line but mark it clean; the fill overwrites it next.
            line_tag   = tag_q[req_index_q][victim_q];
            line_data  = data_q[req_index_q][victim_q];
            line_dirty = 1'b0;
            mem_read_d = 1'b1;
            mem_addr_d = {req_tag_q, req_index_q, {OFFSET_W{1'b0}}};
            state_d    = StFill;
          end
        end
      end
      StFill: begin
        if (bus.mem_ready && mem_read_q) begin
          mem_read_d    = 1'b0;
          line_we       = 1'b1;
          line_data     = bus.mem_data_in;
          line_dirty    = 1'b0;
          l1_data_out_d = bus.mem_data_in;
          state_d       = StResp;
        end
      end
      StResp: begin
        l1_ready_d = 1'b1;
        l1_hit_d   = hit_q;
        state_d    = StRelease;
      end
      StRelease: begin
        if (!bus.l1_read && !bus.l1_write) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      req_tag_q      <= '0;
      req_index_q    <= '0;
      req_data_q     <= '0;
      req_wr_q       <= 1'b0;
      victim_q       <= '0;
      hit_q          <= 1'b0;
      l1_data_out_q  <= '0;
      l1_ready_q     <= 1'b0;
      l1_hit_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_out_q <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_tag_q      <= req_tag_d;
      req_index_q    <= req_index_d;
      req_data_q     <= req_data_d;
      req_wr_q       <= req_wr_d;
      victim_q       <= victim_d;
      hit_q          <= hit_d;
      l1_data_out_q  <= l1_data_out_d;
      l1_ready_q     <= l1_ready_d;
      l1_hit_q       <= l1_hit_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_out_q <= mem_data_out_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      if (line_we) begin
        valid_q[req_index_q][line_way] <= 1'b1;
        dirty_q[req_index_q][line_way] <= line_dirty;
      end
      if (ptr_inc) begin
        ptr_q[req_index_q] <= ptr_q[req_index_q] + WAY_W'(1);
      end
    end
  end

  // Tag/data contents need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[req_index_q][line_way]  <= line_tag;
      data_q[req_index_q][line_way] <= line_data;
    end
  end

  assign bus.l1_data_out  = l1_data_out_q;
  assign bus.l1_ready     = l1_ready_q;
  assign bus.l1_hit       = l1_hit_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data_out = mem_data_out_q;
  assign bus.mem_read     = mem_read_q;
  assign bus.mem_write    = mem_write_q;

endmodule

// File: tb/tb_l2_cache.sv
// Randomised scoreboard bench for l2_cache: a behavioural cache/memory model predicts every
// L1 response and every memory transaction; independent monitors compare what the DUT emits.
module tb_l2_cache;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_cache_if bus ();

  l2_cache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          wr;
    bit          hit;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_t;

  resp_t exp_resp[$];
  mem_t  exp_mem[$];

  int checks = 0;
  int errors = 0;

  // Reference model: sets of 8 ways, plain arrays, spec replacement rules.
  logic [31:0] m_data  [32][8];
  logic [22:0] m_tag   [32][8];
  bit          m_valid [32][8];
  bit          m_dirty [32][8];
  int          m_ptr   [32];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] bus_mem   [logic [31:0]];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] line);
    return (line * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 32; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < 8; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
  endtask

  task automatic model_access(input logic [31:0] addr, input logic [31:0] wdata, input bit wr,
                              output logic [31:0] ed, output bit eh);
    int set, tag, way;
    logic [31:0] line;
    set  = int'(addr[8:4]);
    tag  = int'(addr[31:9]);
    line = {addr[31:4], 4'h0};
    way  = -1;
    eh   = 1'b0;
    ed   = 32'h0;
    for (int w = 0; w < 8; w++)
      if (way < 0 && m_valid[set][w] && m_tag[set][w] == 23'(tag)) way = w;
    if (way >= 0) begin
      eh = 1'b1;
      if (wr) begin
        m_data[set][way]  = wdata;
        m_dirty[set][way] = 1'b1;
      end
      ed = m_data[set][way];
    end else begin
      for (int w = 0; w < 8; w++)
        if (way < 0 && !m_valid[set][w]) way = w;
      if (way < 0) begin
        way        = m_ptr[set];
        m_ptr[set] = (m_ptr[set] + 1) % 8;
      end
      if (m_valid[set][way] && m_dirty[set][way]) begin
        logic [31:0] vaddr;
        vaddr = (32'(m_tag[set][way]) << 9) | (32'(set) << 4);
        exp_mem.push_back('{1'b1, vaddr, m_data[set][way]});
        model_mem[vaddr] = m_data[set][way];
      end
      m_tag[set][way]   = 23'(tag);
      m_valid[set][way] = 1'b1;
      if (wr) begin
        m_data[set][way]  = wdata;
        m_dirty[set][way] = 1'b1;
      end else begin
        exp_mem.push_back('{1'b0, line, 32'h0});
        ed = model_mem.exists(line) ? model_mem[line] : init_word(line);
        m_data[set][way]  = ed;
        m_dirty[set][way] = 1'b0;
      end
    end
  endtask

  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata, input bit wr,
                           input int hold);
    logic [31:0] ed;
    bit eh;
    int lat;
    int extra;
    model_access(addr, wdata, wr, ed, eh);
    exp_resp.push_back('{wr, eh, ed});
    bus.l1_addr    = addr;
    bus.l1_data_in = wdata;
    bus.l1_read    = !wr;
    bus.l1_write   = wr;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.l1_ready && lat < 300);
    if (!bus.l1_ready) check("ready_timeout", {31'h0, bus.l1_ready}, 32'h1);
    if (eh) check("hit_latency", lat, 3);
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.l1_ready) extra++;
    end
    if (hold > 0) check("single_ready_while_held", extra, 0);
    bus.l1_read  = 1'b0;
    bus.l1_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n        = 1'b0;
    bus.l1_read  = 1'b0;
    bus.l1_write = 1'b0;
    repeat (6) @(negedge clk);
    exp_resp.delete();
    exp_mem.delete();
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (bus.mem_read || bus.mem_write)
      check("mem_rd_wr_exclusive", {31'h0, bus.mem_read & bus.mem_write}, 32'h0);
    if (rst_n && bus.l1_ready) begin
      if (exp_resp.size() == 0) begin
        check("unexpected_ready", {31'h0, bus.l1_ready}, 32'h0);
      end else begin
        resp_t r;
        r = exp_resp.pop_front();
        check("l1_hit", {31'h0, bus.l1_hit}, {31'h0, r.hit});
        if (!r.wr) check("l1_data_out", bus.l1_data_out, r.data);
      end
    end
  end

  // Memory responder and transaction monitor
  initial begin : mem_side
    int lat;
    bit abort;
    mem_t m;
    bus.mem_ready   = 1'b0;
    bus.mem_data_in = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.mem_read || bus.mem_write)) begin
        if (exp_mem.size() == 0) begin
          check("unexpected_mem_req", bus.mem_addr, 32'hFFFF_FFFF);
        end else begin
          m = exp_mem.pop_front();
          check("mem_op_is_write", {31'h0, bus.mem_write}, {31'h0, m.wr});
          check("mem_addr", bus.mem_addr, m.addr);
          if (m.wr) check("mem_data_out", bus.mem_data_out, m.data);
        end
        if (bus.mem_write) bus_mem[bus.mem_addr] = bus.mem_data_out;
        lat   = $urandom_range(1, 4);
        abort = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (!rst_n) abort = 1'b1;
        end
        if (!abort && rst_n) begin
          if (bus.mem_read)
            bus.mem_data_in = bus_mem.exists(bus.mem_addr) ? bus_mem[bus.mem_addr]
                                                           : init_word(bus.mem_addr);
          bus.mem_ready = 1'b1;
          @(negedge clk);
          bus.mem_ready   = 1'b0;
          bus.mem_data_in = $urandom;
        end
      end
    end
  end

  initial begin
    logic [31:0] ed;
    bit eh;
    int cnt;
    bus.l1_addr    = 32'h0;
    bus.l1_data_in = 32'h0;
    bus.l1_read    = 1'b0;
    bus.l1_write   = 1'b0;
    model_mem[32'h1230] = 32'hDEAD_BEEF;
    bus_mem[32'h1230]   = 32'hDEAD_BEEF;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_l1_ready", {31'h0, bus.l1_ready}, 32'h0);
    check("rst_l1_hit", {31'h0, bus.l1_hit}, 32'h0);
    check("rst_l1_data_out", bus.l1_data_out, 32'h0);
    check("rst_mem_read", {31'h0, bus.mem_read}, 32'h0);
    check("rst_mem_write", {31'h0, bus.mem_write}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold read, re-read hit, write hit within the same line, read back
    do_access(32'h0000_1230, 32'h0, 1'b0, 0);
    do_access(32'h0000_1230, 32'h0, 1'b0, 0);
    do_access(32'h0000_1234, 32'hCAFE_F00D, 1'b1, 0);
    do_access(32'h0000_1230, 32'h0, 1'b0, 0);
    // Held request: exactly one ready pulse
    do_access(32'h0000_1238, 32'h0, 1'b0, 5);
    // Both strobes high -> treated as a write
    model_access(32'h0000_123C, 32'h1357_9BDF, 1'b1, ed, eh);
    exp_resp.push_back('{1'b1, eh, ed});
    bus.l1_addr = 32'h0000_123C; bus.l1_data_in = 32'h1357_9BDF;
    bus.l1_read = 1'b1; bus.l1_write = 1'b1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!bus.l1_ready && cnt < 300);
    bus.l1_read = 1'b0; bus.l1_write = 1'b0;
    @(negedge clk);
    do_access(32'h0000_1230, 32'h0, 1'b0, 0);

    // Fill set 3, dirty way 0, then force a dirty round-robin eviction
    reset_dut();
    for (int k = 0; k < 8; k++) do_access(32'h30 + k * 32'h200, 32'h0, 1'b0, 0);
    do_access(32'h0000_0030, 32'h11, 1'b1, 0);
    do_access(32'h0000_1030, 32'h0, 1'b0, 0);
    // Clean write-miss install, then evict it again
    do_access(32'h0000_1430, 32'hA5A5_0001, 1'b1, 0);
    for (int k = 11; k <= 18; k++) do_access(32'h30 + k * 32'h200, 32'h0, 1'b0, 0);
    do_access(32'h0000_0030, 32'h0, 1'b0, 0);
    do_access(32'h0000_1430, 32'h0, 1'b0, 0);

    // Reset during a fill
    reset_dut();
    model_access(32'h0000_1230, 32'h0, 1'b0, ed, eh);
    bus.l1_addr = 32'h0000_1230;
    bus.l1_read = 1'b1;
    cnt = 0;
    while (!bus.mem_read && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("fill_started", {31'h0, bus.mem_read}, 32'h1);
    rst_n       = 1'b0;
    bus.l1_read = 1'b0;
    #1;
    check("reset_drops_mem_read", {31'h0, bus.mem_read}, 32'h0);
    check("reset_drops_ready", {31'h0, bus.l1_ready}, 32'h0);
    repeat (6) @(negedge clk);
    exp_resp.delete();
    exp_mem.delete();
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    do_access(32'h0000_1230, 32'h0, 1'b0, 0);

    // Randomised traffic over a few crowded sets
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) << 9) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
      do_access(a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    repeat (10) @(negedge clk);
    check("resp_queue_drained", exp_resp.size(), 0);
    check("mem_queue_drained", exp_mem.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
